// File: rtl/target_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single memory-mapped target.
// The arbiter uses the slave modport; the environment driving requesters and target uses master.
interface target_arbiter_if;
    logic        req0_valid;
    logic [15:0] req0_addr;
    logic [7:0]  req0_wdata;
    logic        req0_rw;
    logic        req0_ready;
    logic        req0_done;
    logic [7:0]  req0_rdata;
    logic        req0_err;

    logic        req1_valid;
    logic [15:0] req1_addr;
    logic [7:0]  req1_wdata;
    logic        req1_rw;
    logic        req1_ready;
    logic        req1_done;
    logic [7:0]  req1_rdata;
    logic        req1_err;

    logic [15:0] tgt_addr;
    logic        tgt_addr_valid;
    logic [7:0]  tgt_wdata;
    logic        tgt_wdata_valid;
    logic        tgt_rw;
    logic [7:0]  tgt_rdata;
    logic        tgt_rdata_valid;
    logic        tgt_ack;
    logic        tgt_ready;

    // Handshake: a requester holds valid and its fields stable until it sees a one-cycle
    // ready pulse; completion is a one-cycle done pulse carrying rdata/err.
    modport slave (
        input  req0_valid, req0_addr, req0_wdata, req0_rw,
        output req0_ready, req0_done, req0_rdata, req0_err,
        input  req1_valid, req1_addr, req1_wdata, req1_rw,
        output req1_ready, req1_done, req1_rdata, req1_err,
        output tgt_addr, tgt_addr_valid, tgt_wdata, tgt_wdata_valid, tgt_rw,
        input  tgt_rdata, tgt_rdata_valid, tgt_ack, tgt_ready
    );

    modport master (
        output req0_valid, req0_addr, req0_wdata, req0_rw,
        input  req0_ready, req0_done, req0_rdata, req0_err,
        output req1_valid, req1_addr, req1_wdata, req1_rw,
        input  req1_ready, req1_done, req1_rdata, req1_err,
        input  tgt_addr, tgt_addr_valid, tgt_wdata, tgt_wdata_valid, tgt_rw,
        output tgt_rdata, tgt_rdata_valid, tgt_ack, tgt_ready
    );
endinterface

// File: rtl/target_arbiter.sv
// Round-robin arbiter sharing one target between two requesters, one transaction at a time,
// with an ack timeout that completes the transaction with an error flag.
module target_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    target_arbiter_if.slave  bus,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  count;
    logic [15:0] lat_addr;
    logic [7:0]  lat_wdata;
    logic        lat_rw;
    logic        owner;
    logic        last_grant;

    logic        addr_strobe;
    logic        wdata_strobe;
    logic        ready0;
    logic        ready1;
    logic        done0;
    logic        done1;
    logic [7:0]  rdata0;
    logic [7:0]  rdata1;
    logic        err0;
    logic        err1;

    logic        grant;
    logic        winner;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;
    logic        sel_rw;
    logic        resp_fire;
    logic [7:0]  resp_rdata;
    logic        resp_err;

    // A tie goes to whichever requester was not served last.
    always_comb begin
        winner = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            winner = ~last_grant;
        end else if (bus.req1_valid) begin
            winner = 1'b1;
        end
        sel_addr  = winner ? bus.req1_addr  : bus.req0_addr;
        sel_wdata = winner ? bus.req1_wdata : bus.req0_wdata;
        sel_rw    = winner ? bus.req1_rw    : bus.req0_rw;
        grant     = bus.tgt_ready && (bus.req0_valid || bus.req1_valid);
    end

    // Ack beats a coincident timeout; read data is only taken on reads flagged valid.
    always_comb begin
        resp_fire  = bus.tgt_ack || (count == LAST_COUNT);
        resp_err   = ~bus.tgt_ack;
        resp_rdata = 8'h00;
        if (bus.tgt_ack && !lat_rw && bus.tgt_rdata_valid) begin
            resp_rdata = bus.tgt_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= 8'h00;
            lat_addr     <= 16'h0000;
            lat_wdata    <= 8'h00;
            lat_rw       <= 1'b0;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            addr_strobe  <= 1'b0;
            wdata_strobe <= 1'b0;
            ready0       <= 1'b0;
            ready1       <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            rdata0       <= 8'h00;
            rdata1       <= 8'h00;
            err0         <= 1'b0;
            err1         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state        <= ISSUE;
                        owner        <= winner;
                        lat_addr     <= sel_addr;
                        lat_wdata    <= sel_wdata;
                        lat_rw       <= sel_rw;
                        ready0       <= ~winner;
                        ready1       <= winner;
                        addr_strobe  <= 1'b1;
                        wdata_strobe <= sel_rw;
                    end
                end

                ISSUE: begin
                    state        <= WAIT;
                    count        <= 8'h00;
                    ready0       <= 1'b0;
                    ready1       <= 1'b0;
                    addr_strobe  <= 1'b0;
                    wdata_strobe <= 1'b0;
                end

                WAIT: begin
                    if (resp_fire) begin
                        state  <= RESP;
                        done0  <= ~owner;
                        done1  <= owner;
                        rdata0 <= owner ? 8'h00 : resp_rdata;
                        rdata1 <= owner ? resp_rdata : 8'h00;
                        err0   <= ~owner & resp_err;
                        err1   <= owner & resp_err;
                    end else if (count != 8'hFF) begin
                        count <= count + 8'h01;
                    end
                end

                RESP: begin
                    state      <= IDLE;
                    last_grant <= owner;
                    done0      <= 1'b0;
                    done1      <= 1'b0;
                    rdata0     <= 8'h00;
                    rdata1     <= 8'h00;
                    err0       <= 1'b0;
                    err1       <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready      = ready0;
    assign bus.req0_done       = done0;
    assign bus.req0_rdata      = rdata0;
    assign bus.req0_err        = err0;
    assign bus.req1_ready      = ready1;
    assign bus.req1_done       = done1;
    assign bus.req1_rdata      = rdata1;
    assign bus.req1_err        = err1;

    // The latch registers double as the target-side address/data/direction outputs.
    assign bus.tgt_addr        = lat_addr;
    assign bus.tgt_wdata       = lat_wdata;
    assign bus.tgt_rw          = lat_rw;
    assign bus.tgt_addr_valid  = addr_strobe;
    assign bus.tgt_wdata_valid = wdata_strobe;

    assign dbg_state           = state;

endmodule

// File: tb/tb_target_arbiter.sv
// Bench for target_arbiter: directed scenarios then randomized rounds, checked against a
// transaction-level model (round-robin rule, target memory, ack-versus-timeout rule).
module tb_target_arbiter;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;
    int         checks = 0;
    int         errors = 0;

    logic       last_grant_m = 1'b1;
    logic [7:0] mem [256];
    logic [9:0] exp_q[$];
    logic       grant_log[$];
    bit         outstanding = 1'b0;
    int         order_exp [4] = '{0, 1, 0, 1};

    target_arbiter_if bus ();

    target_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One target strobe at a time: a second strobe before a done is a protocol breach.
    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding = 1'b0;
        end else begin
            if (bus.tgt_addr_valid) begin
                checks++;
                assert (outstanding == 1'b0) else begin
                    errors++;
                    $error("FAIL strobe_overlap observed=%0d expected=0", outstanding);
                end
                outstanding = 1'b1;
            end
            if (bus.req0_done || bus.req1_done) outstanding = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 32'({bus.req1_ready, bus.req0_ready, bus.req1_done, bus.req0_done,
                                  bus.req1_err, bus.req0_err, bus.tgt_addr_valid,
                                  bus.tgt_wdata_valid, bus.tgt_rw}), 32'd0);
        check({tag, "_data"}, 32'({bus.req1_rdata, bus.req0_rdata, bus.tgt_wdata}), 32'd0);
        check({tag, "_addr"}, 32'(bus.tgt_addr), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check(tag, 32'({bus.req1_ready, bus.req0_ready, bus.req1_done, bus.req0_done,
                        bus.req1_err, bus.req0_err, bus.tgt_addr_valid, bus.req1_rdata,
                        bus.req0_rdata}), 32'd0);
    endtask

    task automatic set_req(input bit n, input logic [15:0] a, input logic [7:0] d, input logic rw);
        if (n) begin
            bus.req1_valid = 1'b1; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_rw = rw;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_rw = rw;
        end
    endtask

    task automatic rand_req(input bit n);
        set_req(n, 16'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        last_grant_m = 1'b1;
        exp_q.delete();
        step();
    endtask

    // k = WAIT cycle in which the target acks (0 = never); stale = ack pulse during ISSUE.
    task automatic run_txn(input string tag, input int k, input bit stale);
        bit          w;
        logic [15:0] a;
        logic [7:0]  d;
        logic        rw;
        bit          exp_err;
        logic [7:0]  exp_rd;
        int          done_at;
        logic [9:0]  e;
        w  = (bus.req0_valid && bus.req1_valid) ? !last_grant_m : bus.req1_valid;
        a  = w ? bus.req1_addr  : bus.req0_addr;
        d  = w ? bus.req1_wdata : bus.req0_wdata;
        rw = w ? bus.req1_rw    : bus.req0_rw;
        exp_err = (k == 0) || (k > T);
        done_at = exp_err ? T + 1 : k + 1;
        exp_rd  = (!exp_err && !rw) ? mem[a[7:0]] : 8'h00;
        exp_q.push_back({w, exp_err, exp_rd});

        step();
        check({tag, "_ready"}, 32'({bus.req1_ready, bus.req0_ready}), w ? 32'd2 : 32'd1);
        check({tag, "_issue"}, 32'({bus.tgt_addr_valid, bus.tgt_wdata_valid, bus.tgt_rw, bus.tgt_addr}),
              32'({1'b1, rw, rw, a}));
        if (rw) check({tag, "_wdata"}, 32'(bus.tgt_wdata), 32'(d));
        grant_log.push_back(w);
        if (w) bus.req1_valid = 1'b0;
        else   bus.req0_valid = 1'b0;
        bus.tgt_ack = stale;
        bus.tgt_rdata_valid = stale;
        bus.tgt_rdata = 8'($urandom);

        for (int c = 1; c <= done_at; c++) begin
            step();
            if (c < done_at) begin
                check({tag, "_wait"}, 32'({bus.req1_ready, bus.req0_ready, bus.req1_done, bus.req0_done,
                                           bus.tgt_addr_valid, bus.tgt_wdata_valid}), 32'd0);
                check({tag, "_hold"}, 32'({bus.tgt_rw, bus.tgt_addr}), 32'({rw, a}));
                bus.tgt_ack = (c == k);
                bus.tgt_rdata_valid = (c == k) ? 1'b1 : 1'($urandom_range(0, 1));
                bus.tgt_rdata = (c == k && !rw) ? mem[a[7:0]] : 8'($urandom);
            end
        end
        bus.tgt_ack = 1'b0;
        bus.tgt_rdata_valid = 1'b0;

        e = exp_q.pop_front();
        check({tag, "_done"}, 32'({bus.req1_done, bus.req0_done}), e[9] ? 32'd2 : 32'd1);
        check({tag, "_rdata"}, 32'(e[9] ? bus.req1_rdata : bus.req0_rdata), 32'(e[7:0]));
        check({tag, "_err"}, 32'(e[9] ? bus.req1_err : bus.req0_err), 32'(e[8]));
        check({tag, "_other"}, 32'(e[9] ? {bus.req0_rdata, bus.req0_err} : {bus.req1_rdata, bus.req1_err}),
              32'd0);
        if (rw && !exp_err) mem[a[7:0]] = d;
        last_grant_m = w;

        step();
        check_quiet({tag, "_idle"});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0; bus.req0_rw = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0; bus.req1_rw = 1'b0;
        bus.tgt_rdata = '0; bus.tgt_rdata_valid = 1'b0; bus.tgt_ack = 1'b0; bus.tgt_ready = 1'b0;

        rst_n = 1'b0;
        step();
        step();
        check_zero("reset");
        rst_n = 1'b1;
        bus.tgt_ready = 1'b1;
        step();

        set_req(1'b0, 16'h0012, 8'hA5, 1'b1);
        run_txn("wr", 1, 1'b0);
        set_req(1'b1, 16'h0012, 8'h00, 1'b0);
        run_txn("rd", 1, 1'b0);

        do_reset();
        grant_log.delete();
        rand_req(1'b0);
        rand_req(1'b1);
        for (int i = 0; i < 4; i++) begin
            run_txn("cont", 1, 1'b0);
            if (i < 3) begin
                if (!bus.req0_valid) rand_req(1'b0);
                else if (!bus.req1_valid) rand_req(1'b1);
            end
        end
        for (int i = 0; i < 4; i++) check("cont_order", 32'(grant_log[i]), 32'(order_exp[i]));
        run_txn("drain", 2, 1'b0);

        set_req(1'b0, 16'h0030, 8'h11, 1'b0);
        run_txn("tmo", 0, 1'b0);
        bus.tgt_ack = 1'b1;
        bus.tgt_rdata_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_quiet("late_ack");
        end
        bus.tgt_ack = 1'b0;
        bus.tgt_rdata_valid = 1'b0;
        step();

        set_req(1'b0, 16'h0012, 8'h00, 1'b0);
        run_txn("ack_edge", T, 1'b0);

        set_req(1'b1, 16'h0040, 8'h00, 1'b0);
        step();
        check("mid_grant", 32'({bus.req1_ready, bus.req0_ready}), 32'd2);
        bus.req1_valid = 1'b0;
        step();
        step();
        bus.tgt_ack = 1'b1;
        bus.tgt_rdata_valid = 1'b1;
        bus.tgt_rdata = 8'h77;
        rst_n = 1'b0;
        step();
        check_zero("mid_rst");
        rst_n = 1'b1;
        last_grant_m = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            step();
            check_quiet("post_rst_ack");
        end
        bus.tgt_ack = 1'b0;
        bus.tgt_rdata_valid = 1'b0;

        bus.tgt_ready = 1'b0;
        rand_req(1'b0);
        rand_req(1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_quiet("tgt_busy");
        end
        bus.tgt_ready = 1'b1;
        run_txn("rst_tie", 1, 1'b0);
        check("rst_tie_owner", 32'(grant_log[$]), 32'd0);
        run_txn("rst_next", 2, 1'b1);
        check("rst_next_owner", 32'(grant_log[$]), 32'd1);

        for (int r = 0; r < 40; r++) begin
            if (!bus.req0_valid && !bus.req1_valid) begin
                case ($urandom_range(0, 2))
                    0: rand_req(1'b0);
                    1: rand_req(1'b1);
                    default: begin rand_req(1'b0); rand_req(1'b1); end
                endcase
            end else if ($urandom_range(0, 1) == 1) begin
                if (!bus.req0_valid) rand_req(1'b0);
                else if (!bus.req1_valid) rand_req(1'b1);
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.tgt_ready = 1'b0;
                for (int i = 0; i < int'($urandom_range(1, 2)); i++) begin
                    step();
                    check_quiet("rnd_busy");
                end
                bus.tgt_ready = 1'b1;
            end
            run_txn("rnd", int'($urandom_range(0, T + 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
